count_down_timer: RTL and testbench

Parametrised successor to the basic down-counter for the ADC project. It is a loadable, prescaled down-count timer with start/stop control, one-shot or auto-reload mode, and a single-cycle terminal-count pulse. It paces ADC sample/conversion intervals and other fixed-length waits from one system clock. Count width and prescaler width are generics, so the same block serves short settling delays and long sample periods.

---
 rtl/count_down_timer.sv | 136 +++++++++++++
 tb/tb_count_down_timer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/count_down_timer.sv
// count_down_timer: loadable, prescaled down-count timer with start/stop
// control, one-shot or auto-reload mode and a one-cycle terminal-count pulse.
// Every output comes straight from a register.
module count_down_timer #(
    parameter int unsigned number_of_bits = 8,
    parameter int unsigned prescale_bits  = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      load,
    input  logic [number_of_bits-1:0] load_val,
    input  logic [prescale_bits-1:0]  prescale_div,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      auto_reload,
    output logic [number_of_bits-1:0] count_val,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned CW = number_of_bits;
    localparam int unsigned PW = prescale_bits;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] reload_q, reload_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;

    // Prescaler compare: one count step is due on this edge.
    logic tick;
    assign tick = (pre_q == prescale_div);

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            pre_q    <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            pre_q    <= pre_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state and datapath update; load beats stop, which beats start.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        pre_d    = pre_q;
        done_d   = 1'b0;

        if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            pre_d    = '0;
            state_d  = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A simultaneous stop suppresses start.
                    if (start && !stop) begin
                        pre_d = '0;
                        if (count_q != '0) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_EXPIRED;
                            done_d  = 1'b1;
                        end
                    end
                end

                ST_EXPIRED: begin
                    // Restart from the reload value; an empty reload expires again.
                    if (start && !stop) begin
                        count_d = reload_q;
                        pre_d   = '0;
                        if (reload_q != '0) begin
                            state_d = ST_RUN;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    if (stop) begin
                        state_d = ST_IDLE;
                        pre_d   = '0;
                    end else if (tick) begin
                        pre_d = '0;
                        if (count_q > CW'(1)) begin
                            count_d = count_q - CW'(1);
                        end else if (count_q == CW'(1)) begin
                            done_d = 1'b1;
                            if (auto_reload && (reload_q != '0)) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = ST_EXPIRED;
                            end
                        end
                    end else begin
                        pre_d = pre_q + PW'(1);
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_RUN);
    end

    assign count_val = count_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_count_down_timer.sv
// Self-checking bench for count_down_timer: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a reference.
module tb_count_down_timer;

    localparam int unsigned NB   = 8;
    localparam int unsigned PB   = 4;
    localparam int          PMOD = 1 << PB;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          load;
    logic [NB-1:0] load_val;
    logic [PB-1:0] prescale_div;
    logic          start;
    logic          stop;
    logic          auto_reload;
    logic [NB-1:0] count_val;
    logic          busy;
    logic          done;

    count_down_timer #(
        .number_of_bits(NB),
        .prescale_bits (PB)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (load),
        .load_val    (load_val),
        .prescale_div(prescale_div),
        .start       (start),
        .stop        (stop),
        .auto_reload (auto_reload),
        .count_val   (count_val),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Reference state: mode 0 = stopped, 1 = counting, 2 = expired.
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_EXP  = 2;

    int m_mode   = M_IDLE;
    int m_cnt    = 0;
    int m_reload = 0;
    int m_pre    = 0;
    int m_done   = 0;

    int n_checks = 0;
    int n_errors = 0;

    // Literal expectations for the outputs after the coming rising edge.
    bit pin_en = 1'b0;
    int pin_cnt, pin_busy, pin_done;
    string pin_name = "";

    // One clock edge of the timer rules, applied to the sampled inputs.
    task automatic model_step();
        m_done = 0;
        if (!reset_n) begin
            m_mode = M_IDLE; m_cnt = 0; m_reload = 0; m_pre = 0;
        end else if (load) begin
            m_cnt = int'(load_val); m_reload = int'(load_val);
            m_pre = 0; m_mode = M_IDLE;
        end else if (stop) begin
            if (m_mode == M_RUN) begin
                m_mode = M_IDLE; m_pre = 0;
            end
        end else if (start && m_mode != M_RUN) begin
            m_pre = 0;
            if (m_mode == M_EXP) m_cnt = m_reload;
            if (m_cnt != 0) m_mode = M_RUN;
            else begin m_mode = M_EXP; m_done = 1; end
        end else if (m_mode == M_RUN) begin
            if (m_pre == int'(prescale_div)) begin
                m_pre = 0;
                if (m_cnt > 1) m_cnt = m_cnt - 1;
                else begin
                    m_done = 1;
                    if (auto_reload && m_reload != 0) m_cnt = m_reload;
                    else begin m_cnt = 0; m_mode = M_EXP; end
                end
            end else begin
                m_pre = (m_pre + 1) % PMOD;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: actual=%0d expected=%0d", nm, $time, act, exp);
        end
    endtask

    // Compare process: advance the reference and check every cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            model_step();
            chk("model_count", 32'(count_val), 32'(m_cnt));
            chk("model_busy",  32'(busy),      32'(m_mode == M_RUN));
            chk("model_done",  32'(done),      32'(m_done));
            if (pin_en) begin
                chk({pin_name, "_count"}, 32'(count_val), 32'(pin_cnt));
                chk({pin_name, "_busy"},  32'(busy),      32'(pin_busy));
                chk({pin_name, "_done"},  32'(done),      32'(pin_done));
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        pin_en = 1'b0;
    endtask

    task automatic pin(input string nm, input int c, input int b, input int d);
        pin_en   = 1'b1;
        pin_name = nm;
        pin_cnt  = c;
        pin_busy = b;
        pin_done = d;
    endtask

    task automatic do_load(input int v, input int p);
        load = 1'b1; load_val = NB'(v); prescale_div = PB'(p);
    endtask

    initial begin
        reset_n = 1'b0; load = 1'b0; load_val = '0; prescale_div = '0;
        start = 1'b0; stop = 1'b0; auto_reload = 1'b0;
        pin("reset", 0, 0, 0);
        cyc(); pin("reset", 0, 0, 0);
        cyc(); reset_n = 1'b1;

        // One-shot, 3 counts, no prescale.
        cyc(); do_load(3, 0);
        cyc(); load = 1'b0; start = 1'b1; pin("os_e0", 3, 1, 0);
        cyc(); start = 1'b0; pin("os_e1", 2, 1, 0);
        cyc(); pin("os_e2", 1, 1, 0);
        cyc(); pin("os_e3", 0, 0, 1);
        cyc(); pin("os_e4", 0, 0, 0);

        // Prescaled: 2 counts, divide by 4.
        cyc(); do_load(2, 3);
        cyc(); load = 1'b0; start = 1'b1; pin("ps_e0", 2, 1, 0);
        for (int i = 1; i <= 9; i++) begin
            cyc(); start = 1'b0;
            pin("ps", (i < 4) ? 2 : ((i < 8) ? 1 : 0), (i < 8) ? 1 : 0, (i == 8) ? 1 : 0);
        end

        // Periodic mode: reload 4, divide by 2.
        cyc(); do_load(4, 1); auto_reload = 1'b1;
        cyc(); load = 1'b0; start = 1'b1; pin("ar_e0", 4, 1, 0);
        for (int i = 1; i <= 24; i++) begin
            cyc(); start = 1'b0;
            pin("ar", 4 - ((i / 2) % 4), 1, (i % 8 == 0) ? 1 : 0);
        end
        cyc(); auto_reload = 1'b0; stop = 1'b1; pin("ar_stop", 4, 0, 0);
        cyc(); stop = 1'b0;

        // Pause and resume: 4 ticks, 20 paused cycles, 6 more ticks.
        cyc(); do_load(10, 0);
        cyc(); load = 1'b0; start = 1'b1; pin("pr_e0", 10, 1, 0);
        for (int i = 1; i <= 4; i++) begin
            cyc(); start = 1'b0; pin("pr_run", 10 - i, 1, 0);
        end
        cyc(); stop = 1'b1; pin("pr_stop", 6, 0, 0);
        repeat (20) begin
            cyc(); stop = 1'b0; pin("pr_hold", 6, 0, 0);
        end
        cyc(); start = 1'b1; pin("pr_resume", 6, 1, 0);
        for (int i = 1; i <= 6; i++) begin
            cyc(); start = 1'b0; pin("pr_tail", 6 - i, (i < 6) ? 1 : 0, (i == 6) ? 1 : 0);
        end

        // Reset in the middle of a long count, then silence.
        cyc(); do_load(200, 0);
        cyc(); load = 1'b0; start = 1'b1;
        repeat (10) begin
            cyc(); start = 1'b0;
        end
        cyc(); reset_n = 1'b0; pin("rst_mid", 0, 0, 0);
        repeat (300) begin
            cyc(); reset_n = 1'b1; pin("rst_quiet", 0, 0, 0);
        end

        // start and stop together while stopped.
        cyc(); do_load(5, 0);
        cyc(); load = 1'b0; start = 1'b1; stop = 1'b1; pin("ss_idle", 5, 0, 0);
        cyc(); start = 1'b0; stop = 1'b0; pin("ss_after", 5, 0, 0);

        // load while counting.
        cyc(); start = 1'b1; pin("ld_run0", 5, 1, 0);
        cyc(); start = 1'b0; pin("ld_run1", 4, 1, 0);
        cyc(); do_load(7, 0); pin("ld_mid", 7, 0, 0);
        cyc(); load = 1'b0; pin("ld_hold", 7, 0, 0);

        // Zero count: start expires immediately, twice.
        cyc(); do_load(0, 0); pin("z_load", 0, 0, 0);
        cyc(); load = 1'b0; start = 1'b1; pin("z_start", 0, 0, 1);
        cyc(); start = 1'b0; pin("z_after", 0, 0, 0);
        cyc(); start = 1'b1; pin("z_again", 0, 0, 1);
        cyc(); start = 1'b0; pin("z_after2", 0, 0, 0);

        // Restart from expired with a non-zero reload.
        cyc(); do_load(2, 0);
        cyc(); load = 1'b0; start = 1'b1; pin("ex_e0", 2, 1, 0);
        cyc(); start = 1'b0; pin("ex_e1", 1, 1, 0);
        cyc(); pin("ex_e2", 0, 0, 1);
        cyc(); pin("ex_e3", 0, 0, 0);
        cyc(); start = 1'b1; pin("ex_re0", 2, 1, 0);
        cyc(); start = 1'b0; pin("ex_re1", 1, 1, 0);
        cyc(); pin("ex_re2", 0, 0, 1);

        // Randomized traffic, checked against the reference only.
        for (int i = 0; i < 5000; i++) begin
            cyc();
            reset_n = ($urandom_range(0, 299) != 0);
            load    = ($urandom_range(0, 29) == 0);
            case ($urandom_range(0, 3))
                0:       load_val = '0;
                1:       load_val = NB'(1);
                2:       load_val = NB'($urandom_range(2, 12));
                default: load_val = NB'($urandom);
            endcase
            start = ($urandom_range(0, 5) == 0);
            stop  = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 49) == 0)
                prescale_div = ($urandom_range(0, 3) == 0) ? PB'($urandom) : PB'($urandom_range(0, 2));
            if ($urandom_range(0, 99) == 0)
                auto_reload = ~auto_reload;
        end

        cyc();
        reset_n = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0;
        cyc();
        cyc();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
